// File: rtl/psum_accum.sv
// Partial-sum accumulator behind the 8x8 signed DSP multiplier: realigns operand-side
// framing flags with the product stream and sums each kernel window with saturation.
module psum_accum #(
    parameter int MUL_LAT = 3,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_clr,
    input  logic               i_vld,
    input  logic               i_first,
    input  logic               i_last,
    input  logic [15:0]        i_prod,
    output logic [ACC_W-1:0]   o_acc,
    output logic               o_vld,
    output logic [CNT_W-1:0]   o_cnt,
    output logic               o_ovf,
    output logic               o_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [MUL_LAT-1:0] dly_vld_r;
    logic [MUL_LAT-1:0] dly_first_r;
    logic [MUL_LAT-1:0] dly_last_r;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               done_s;
    logic               start_s;
    logic               frame_err_s;

    logic [ACC_W-1:0]   res_acc_r;
    logic [CNT_W-1:0]   res_cnt_r;
    logic               res_ovf_r;
    logic               res_vld_r;

    logic               a_vld_s;
    logic               a_first_s;
    logic               a_last_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W:0]     sum_s;
    logic               sat_s;

    assign a_vld_s    = dly_vld_r[MUL_LAT-1];
    assign a_first_s  = a_vld_s & dly_first_r[MUL_LAT-1];
    assign a_last_s   = a_vld_s & dly_last_r[MUL_LAT-1];
    assign prod_ext_s = {{(ACC_W-16){i_prod[15]}}, i_prod};

    // One guard bit above the accumulator: the top two sum bits disagree exactly on signed overflow.
    assign sum_s = {acc_r[ACC_W-1], acc_r} + {prod_ext_s[ACC_W-1], prod_ext_s};
    assign sat_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];

    // Flag delay line matching the multiplier latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_vld_r   <= {MUL_LAT{1'b0}};
            dly_first_r <= {MUL_LAT{1'b0}};
            dly_last_r  <= {MUL_LAT{1'b0}};
        end else if (i_clr) begin
            dly_vld_r   <= {MUL_LAT{1'b0}};
            dly_first_r <= {MUL_LAT{1'b0}};
            dly_last_r  <= {MUL_LAT{1'b0}};
        end else begin
            dly_vld_r[0]   <= i_vld;
            dly_first_r[0] <= i_first;
            dly_last_r[0]  <= i_last;
            for (int k = 1; k < MUL_LAT; k++) begin
                dly_vld_r[k]   <= dly_vld_r[k-1];
                dly_first_r[k] <= dly_first_r[k-1];
                dly_last_r[k]  <= dly_last_r[k-1];
            end
        end
    end

    // Group framing decode for the aligned term.
    always_comb begin
        start_s     = 1'b1;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s     = 1'b1;
                frame_err_s = ~a_first_s;
            end
            ST_ACC: begin
                start_s     = a_first_s;
                frame_err_s = a_first_s;
            end
            default: begin
                start_s     = 1'b1;
                frame_err_s = 1'b0;
            end
        endcase
    end

    // Next-state and accumulator datapath.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        err_nxt_s   = err_r;
        done_s      = 1'b0;
        if (a_vld_s) begin
            if (start_s) begin
                acc_nxt_s = prod_ext_s;
                cnt_nxt_s = CNT_ONE;
                ovf_nxt_s = 1'b0;
                err_nxt_s = err_r | frame_err_s;
            end else begin
                acc_nxt_s = sat_s ? (sum_s[ACC_W] ? ACC_MIN : ACC_MAX) : sum_s[ACC_W-1:0];
                cnt_nxt_s = (&cnt_r) ? cnt_r : (cnt_r + CNT_ONE);
                ovf_nxt_s = ovf_r | sat_s;
                err_nxt_s = err_r;
            end
            if (a_last_s) begin
                state_nxt_s = ST_IDLE;
                done_s      = 1'b1;
            end else begin
                state_nxt_s = ST_ACC;
                done_s      = 1'b0;
            end
        end else begin
            state_nxt_s = state_r;
            done_s      = 1'b0;
        end
    end

    // State, accumulator and sticky error registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else if (i_clr) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Result registers: captured on group completion, held otherwise (including across a flush).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_acc_r <= {ACC_W{1'b0}};
            res_cnt_r <= {CNT_W{1'b0}};
            res_ovf_r <= 1'b0;
            res_vld_r <= 1'b0;
        end else if (i_clr) begin
            res_vld_r <= 1'b0;
        end else begin
            res_vld_r <= done_s;
            if (done_s) begin
                res_acc_r <= acc_nxt_s;
                res_cnt_r <= cnt_nxt_s;
                res_ovf_r <= ovf_nxt_s;
            end else begin
                res_acc_r <= res_acc_r;
            end
        end
    end

    assign o_acc = res_acc_r;
    assign o_cnt = res_cnt_r;
    assign o_ovf = res_ovf_r;
    assign o_vld = res_vld_r;
    assign o_err = err_r;

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: a 32-bit and a 17-bit instance share one stimulus stream and are
// checked every cycle against an arithmetic model of the group/saturation rules.
module tb_psum_accum;

    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic               i_clr, i_vld, i_first, i_last;
    logic [15:0]        i_prod;
    logic [31:0]        acc32;
    logic [16:0]        acc17;
    logic [7:0]         cnt32, cnt17;
    logic               vld32, vld17, ovf32, ovf17, err32, err17;

    int total = 0;
    int bad   = 0;

    // Product pipeline standing in for the multiplier: entry LAT-1 arrives this cycle.
    bit                 p_vld[LAT];
    bit                 p_first[LAT];
    bit                 p_last[LAT];
    logic signed [15:0] p_prod[LAT];

    // Reference model state.
    int     wd[2] = '{32, 17};
    longint m_sum[2];
    bit     m_ovf[2];
    int     m_cnt;
    bit     m_open;
    bit     m_err;
    longint h_sum[2];
    bit     h_ovf[2];
    int     h_cnt;
    bit     exp_vld;

    psum_accum #(.MUL_LAT(LAT), .ACC_W(32), .CNT_W(8)) u_dut32 (
        .clk(clk), .rstn(rstn), .i_clr(i_clr), .i_vld(i_vld), .i_first(i_first),
        .i_last(i_last), .i_prod(i_prod), .o_acc(acc32), .o_vld(vld32),
        .o_cnt(cnt32), .o_ovf(ovf32), .o_err(err32)
    );

    psum_accum #(.MUL_LAT(LAT), .ACC_W(17), .CNT_W(8)) u_dut17 (
        .clk(clk), .rstn(rstn), .i_clr(i_clr), .i_vld(i_vld), .i_first(i_first),
        .i_last(i_last), .i_prod(i_prod), .o_acc(acc17), .o_vld(vld17),
        .o_cnt(cnt17), .o_ovf(ovf17), .o_err(err17)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input longint v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return 64'(v) & m;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < LAT; k++) begin
            p_vld[k] = 1'b0; p_first[k] = 1'b0; p_last[k] = 1'b0; p_prod[k] = 16'sd0;
        end
        for (int w = 0; w < 2; w++) begin
            m_sum[w] = 0; m_ovf[w] = 1'b0;
        end
        m_cnt = 0; m_open = 1'b0; m_err = 1'b0; exp_vld = 1'b0;
    endtask

    task automatic check_all();
        chk("vld32", 64'(vld32), 64'(exp_vld));
        chk("vld17", 64'(vld17), 64'(exp_vld));
        chk("acc32", 64'(acc32), wmask(h_sum[0], 32));
        chk("acc17", 64'(acc17), wmask(h_sum[1], 17));
        chk("cnt32", 64'(cnt32), 64'(h_cnt));
        chk("cnt17", 64'(cnt17), 64'(h_cnt));
        chk("ovf32", 64'(ovf32), 64'(h_ovf[0]));
        chk("ovf17", 64'(ovf17), 64'(h_ovf[1]));
        chk("err32", 64'(err32), 64'(m_err));
        chk("err17", 64'(err17), 64'(m_err));
    endtask

    // One clock: launch operands' flags, present the product due this cycle, model, check.
    task automatic step(input bit vld, input bit first, input bit last,
                        input logic signed [15:0] prod, input bit clr = 1'b0);
        bit                 a_v, a_f, a_l;
        logic signed [15:0] a_p;
        longint             hi, lo;
        a_v = p_vld[LAT-1];
        a_f = p_first[LAT-1] & a_v;
        a_l = p_last[LAT-1] & a_v;
        a_p = p_prod[LAT-1];
        i_vld = vld; i_first = first; i_last = last; i_clr = clr;
        i_prod = a_v ? a_p : 16'($urandom);
        exp_vld = 1'b0;
        if (clr) begin
            for (int k = 0; k < LAT; k++) p_vld[k] = 1'b0;
            for (int w = 0; w < 2; w++) begin m_sum[w] = 0; m_ovf[w] = 1'b0; end
            m_cnt = 0; m_open = 1'b0; m_err = 1'b0;
        end else begin
            if (a_v) begin
                if (a_f || !m_open) begin
                    if (a_f == m_open) m_err = 1'b1;
                    for (int w = 0; w < 2; w++) begin
                        m_sum[w] = longint'(a_p); m_ovf[w] = 1'b0;
                    end
                    m_cnt = 1;
                end else begin
                    for (int w = 0; w < 2; w++) begin
                        hi = (longint'(1) << (wd[w] - 1)) - 1;
                        lo = -(longint'(1) << (wd[w] - 1));
                        m_sum[w] = m_sum[w] + longint'(a_p);
                        if (m_sum[w] > hi) begin m_sum[w] = hi; m_ovf[w] = 1'b1; end
                        if (m_sum[w] < lo) begin m_sum[w] = lo; m_ovf[w] = 1'b1; end
                    end
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
                m_open = !a_l;
                if (a_l) begin
                    exp_vld = 1'b1;
                    h_cnt = m_cnt;
                    for (int w = 0; w < 2; w++) begin h_sum[w] = m_sum[w]; h_ovf[w] = m_ovf[w]; end
                end
            end
            for (int k = LAT - 1; k > 0; k--) begin
                p_vld[k] = p_vld[k-1]; p_first[k] = p_first[k-1];
                p_last[k] = p_last[k-1]; p_prod[k] = p_prod[k-1];
            end
            p_vld[0] = vld; p_first[0] = first; p_last[0] = last; p_prod[0] = prod;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'sd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        chk("rst_vld32", 64'(vld32), 64'd0);
        chk("rst_acc32", 64'(acc32), 64'd0);
        chk("rst_cnt32", 64'(cnt32), 64'd0);
        chk("rst_ovf32", 64'(ovf32), 64'd0);
        chk("rst_err32", 64'(err32), 64'd0);
        chk("rst_acc17", 64'(acc17), 64'd0);
        chk("rst_vld17", 64'(vld17), 64'd0);
        model_clear();
        h_sum[0] = 0; h_sum[1] = 0; h_ovf[0] = 1'b0; h_ovf[1] = 1'b0; h_cnt = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    logic signed [15:0] g2[5] = '{16'sd100, -16'sd20, 16'sd5, -16'sd1, -16'sd1};

    initial begin
        i_clr = 1'b0; i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0; i_prod = 16'h0000;
        #1;
        do_reset();

        // Nine products of -6 in one window.
        for (int i = 0; i < 9; i++) step(1'b1, i == 0, i == 8, -16'sd6);
        drain(LAT + 2);
        chk("t1_acc", 64'(acc32), 64'hFFFF_FFCA);
        chk("t1_cnt", 64'(cnt32), 64'd9);
        chk("t1_ovf", 64'(ovf32), 64'd0);
        chk("t1_err", 64'(err32), 64'd0);

        // Back-to-back groups {100,-20,5} and {-1,-1}.
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0) || (i == 3), (i == 2) || (i == 4), g2[i]);
        drain(LAT + 2);
        chk("t2_acc", 64'(acc32), 64'hFFFF_FFFE);
        chk("t2_cnt", 64'(cnt32), 64'd2);

        // Single-term group at the negative extreme, surrounded by bubbles.
        drain(2);
        step(1'b1, 1'b1, 1'b1, -16'sd32768);
        drain(LAT + 3);
        chk("t3_acc", 64'(acc32), 64'hFFFF_8000);
        chk("t3_cnt", 64'(cnt32), 64'd1);

        // Three max products: saturates at 17 bits, not at 32.
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, i == 2, 16'sd32767);
        drain(LAT + 2);
        chk("t4_acc17", 64'(acc17), 64'h0_FFFF);
        chk("t4_ovf17", 64'(ovf17), 64'd1);
        chk("t4_acc32", 64'(acc32), 64'd98301);
        chk("t4_ovf32", 64'(ovf32), 64'd0);

        // first mid-group discards the open group.
        step(1'b1, 1'b1, 1'b0, 16'sd10);
        step(1'b1, 1'b0, 1'b0, 16'sd10);
        step(1'b1, 1'b1, 1'b1, 16'sd7);
        drain(LAT + 2);
        chk("t5_acc", 64'(acc32), 64'd7);
        chk("t5_cnt", 64'(cnt32), 64'd1);
        chk("t5_err", 64'(err32), 64'd1);

        // Flush, then a term without first starts an implicit group.
        step(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1);
        chk("t6_err_clr", 64'(err32), 64'd0);
        step(1'b1, 1'b0, 1'b1, 16'sd5);
        drain(LAT + 2);
        chk("t6_err", 64'(err32), 64'd1);
        chk("t6_acc", 64'(acc32), 64'd5);

        // Long group: term count saturates at all-ones.
        for (int i = 0; i < 260; i++) step(1'b1, i == 0, i == 259, 16'sd1);
        drain(LAT + 2);
        chk("t7_cnt", 64'(cnt32), 64'd255);
        chk("t7_acc", 64'(acc32), 64'd260);

        // Reset mid-group, then a fresh group {3,4}.
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b0, -16'sd6);
        do_reset();
        drain(LAT + 2);
        step(1'b1, 1'b1, 1'b0, 16'sd3);
        step(1'b1, 1'b0, 1'b1, 16'sd4);
        drain(LAT + 2);
        chk("t8_acc", 64'(acc32), 64'd7);
        chk("t8_cnt", 64'(cnt32), 64'd2);

        // Randomized framing, products and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 16'($urandom), $urandom_range(0, 49) == 0);
        end
        drain(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Downstream partner of the 8x8 signed DSP multiplier.
- Consumes the 16-bit signed product stream and sums one kernel window (e.g. 9 products for a 3x3 tap) into a wide partial sum.
- Emits the partial sum with a one-cycle valid pulse, term count and overflow status.
- Operand-side valid/first/last flags enter in the same cycle the operands enter the multiplier; this block delays them internally to line up with the DSP output.

Parameters:
MUL_LAT, 3, multiplier latency in cycles from operands-in to product-valid (>=1)
ACC_W, 32, accumulator/output width in bits (>=17)
CNT_W, 8, term-counter width

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
i_clr  input  1  synchronous flush, active high
i_vld  input  1  operands presented to multiplier this cycle
i_first  input  1  first term of a group (qualified by i_vld)
i_last  input  1  last term of a group (qualified by i_vld)
i_prod  input  16  signed product from multiplier, valid MUL_LAT cycles after matching i_vld
o_acc  output  ACC_W  signed partial sum of the completed group
o_vld  output  1  one-cycle pulse: o_acc/o_cnt/o_ovf valid
o_cnt  output  CNT_W  number of terms in the completed group
o_ovf  output  1  group saturated (valid with o_vld)
o_err  output  1  sticky framing error

Behaviour:
- Reset (rstn=0, asynchronous): delay line, accumulator, counter, state, all outputs -> 0; state IDLE.
- Delay line: MUL_LAT-stage shift register of {vld, first, last}.
  - Tail gives aligned a_vld/a_first/a_last, coincident with i_prod.
  - first/last ignored when their vld bit is 0.
- i_prod is sign-extended to ACC_W before use. i_prod is ignored when a_vld=0.
- States: IDLE (no open group), ACC (group open).
- On a_vld:
  - Start term (a_first=1, or state IDLE): acc <= sext(i_prod); cnt <= 1; ovf <= 0.
  - Otherwise: acc <= acc + sext(i_prod), saturated to ACC_W signed max/min; cnt <= cnt+1, saturating at all-ones; ovf |= saturation occurred.
  - State after the term: ACC, or IDLE if a_last=1.
- On a_vld & a_last, in the following cycle:
  - o_acc = final sum including this term.
  - o_cnt = final count; o_ovf = final ovf.
  - o_vld = 1 for exactly that one cycle.
- o_acc/o_cnt/o_ovf hold their value until the next o_vld. o_vld=0 otherwise.
- Latency: o_vld rises MUL_LAT+1 cycles after the i_vld&i_last launch cycle.
- Throughput: one term per cycle, with no bubble between groups. A last term followed by a first term on the next cycle is legal.
- a_first & a_last together: single-term group; o_acc=sext(i_prod), o_cnt=1.
- Framing errors (set o_err; it stays set until reset or i_clr):
  - a_vld & a_first while in ACC: open group discarded without output; new group starts.
  - a_vld & !a_first while in IDLE: term starts an implicit group.
- No backpressure: the downstream stage must accept o_vld unconditionally.
- i_clr=1 (synchronous):
  - Clears delay line, acc, cnt, ovf, o_err; state -> IDLE.
  - o_vld is 0 in the following cycle. o_acc/o_cnt/o_ovf are held.
  - Terms already in flight are dropped.
  - Priority: i_clr over all other inputs in the same cycle.
- rstn deassertion mid-stream: in-flight flags are lost. Products arriving afterwards carry a_vld=0 and are ignored.

Test Plan:
- 9-term group, every product -6 (w=3, x=-2), first on term 0, last on term 8, back-to-back -> single o_vld pulse 4 cycles after the last launch; o_acc=-54, o_cnt=9, o_ovf=0, o_err=0.
- Two back-to-back groups, products {100,-20,5} then {-1,-1} -> o_acc=85 / o_cnt=3, then o_acc=-2 / o_cnt=2 on consecutive group ends; no lost term.
- Single-term group (first&last) with product -32768 -> o_acc=0xFFFF8000 (ACC_W=32), o_cnt=1; bubbles (i_vld=0, garbage i_prod) ignored.
- ACC_W=17, group of three products 32767 each -> o_acc=65535 (max), o_ovf=1.
- Framing errors:
  - first issued mid-group after products {10,10}, new group {7} closed with last -> o_acc=7, o_cnt=1, o_err=1.
  - After i_clr, a term with i_vld but no first -> implicit start, o_err=1.
- Reset mid-group: rstn pulsed low after 4 of 9 terms -> all outputs 0 immediately; no o_vld for that group. A fresh 2-term group {3,4} afterwards -> o_acc=7.
